// File: rtl/vedic_divider_4bit_pkg.sv
//------------------------------------------------------------------------------
// Module   : vedic_divider_4bit_pkg
// Brief    : Shared state encoding and default width for the restoring divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vedic_divider_4bit_pkg;

    localparam int c_default_width = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/vedic_divider_4bit_if.sv
//------------------------------------------------------------------------------
// Module   : vedic_divider_4bit_if
// Brief    : Start/done handshake and operand/result bus of the divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vedic_divider_4bit_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/vedic_divider_4bit_div_step.sv
//------------------------------------------------------------------------------
// Module   : vedic_divider_4bit_div_step
// Brief    : One combinational restoring-division step (shift in, trial subtract).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vedic_divider_4bit_div_step #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] i_rem,
    input  wire logic             i_bit,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH-1:0] o_rem,
    output logic                  o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // The restored remainder is always below the divisor, so the shifted
    // value's MSB is zero whenever the subtraction is rejected.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign o_qbit  = ~w_diff[WIDTH];
    assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/vedic_divider_4bit.sv
//------------------------------------------------------------------------------
// Module   : vedic_divider_4bit
// Brief    : Sequential unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vedic_divider_4bit
    import vedic_divider_4bit_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  wire logic          clk,
    input  wire logic          rst,
    vedic_divider_4bit_if.slave bus
);

    localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_next;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_dvd_sh;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_qsh;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem_out;
    logic               r_dbz;
    logic               w_accept;
    logic [WIDTH-1:0]   w_rem_next;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_q_next;

    assign w_accept = bus.start && (r_state != ST_RUN);
    assign w_q_next = {r_qsh[WIDTH-2:0], w_qbit};

    vedic_divider_4bit_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd_sh[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) w_next = (bus.divisor == '0) ? ST_DONE : ST_RUN;
                else          w_next = ST_IDLE;
            end
            ST_RUN:  if (r_count == '0) w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_dvd_sh  <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_qsh     <= '0;
            r_quot    <= '0;
            r_rem_out <= '0;
            r_dbz     <= 1'b0;
        end else if (w_accept) begin
            r_count  <= c_cnt_w'(WIDTH - 1);
            r_dvd_sh <= bus.dividend;
            r_dvs    <= bus.divisor;
            r_rem    <= '0;
            r_qsh    <= '0;
            // A zero divisor skips RUN and publishes the saturated result now.
            if (bus.divisor == '0) begin
                r_quot    <= '1;
                r_rem_out <= bus.dividend;
                r_dbz     <= 1'b1;
            end else begin
                r_dbz     <= 1'b0;
            end
        end else if (r_state == ST_RUN) begin
            r_dvd_sh <= {r_dvd_sh[WIDTH-2:0], 1'b0};
            r_rem    <= w_rem_next;
            r_qsh    <= w_q_next;
            r_count  <= r_count - 1'b1;
            if (r_count == '0) begin
                r_quot    <= w_q_next;
                r_rem_out <= w_rem_next;
            end
        end
    end

    assign bus.busy        = (r_state == ST_RUN);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem_out;
    assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_vedic_divider_4bit.sv
//------------------------------------------------------------------------------
// Module   : tb_vedic_divider_4bit
// Brief    : Self-checking bench: directed table, corner sequences, exhaustive and random sweeps.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vedic_divider_4bit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    vedic_divider_4bit_if #(.WIDTH(4)) bus ();

    vedic_divider_4bit #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division with the saturated divide-by-zero rule.
    task automatic ref_div(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = 15; r = a; z = 1;
        end else begin
            q = a / b; r = a % b; z = 0;
        end
    endtask

    // Issue one request at the next falling edge and wait (bounded) for done.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_op(input string tag, input logic [3:0] a, input logic [3:0] b);
        int lat, bc, q, r, z;
        run_op(a, b, lat, bc);
        ref_div(int'(a), int'(b), q, r, z);
        chk({tag, "_done"}, int'(bus.done), 1);
        chk({tag, "_lat"},  lat, (b == 4'd0) ? 1 : 5);
        chk({tag, "_q"},    int'(bus.quotient), q);
        chk({tag, "_r"},    int'(bus.remainder), r);
        chk({tag, "_dbz"},  int'(bus.div_by_zero), z);
    endtask

    initial begin
        int lat, bc, dones;

        tbl[0] = '{a: 4'd13, b: 4'd3, q: 4'd4,  r: 4'd1, z: 1'b0, lat: 5};
        tbl[1] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0, z: 1'b0, lat: 5};
        tbl[2] = '{a: 4'd2,  b: 4'd9, q: 4'd0,  r: 4'd2, z: 1'b0, lat: 5};
        tbl[3] = '{a: 4'd0,  b: 4'd5, q: 4'd0,  r: 4'd0, z: 1'b0, lat: 5};
        tbl[4] = '{a: 4'd7,  b: 4'd0, q: 4'd15, r: 4'd7, z: 1'b1, lat: 1};
        tbl[5] = '{a: 4'd6,  b: 4'd2, q: 4'd3,  r: 4'd0, z: 1'b0, lat: 5};

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_q",    int'(bus.quotient), 0);
        chk("rst_r",    int'(bus.remainder), 0);
        chk("rst_dbz",  int'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table; 7/0 followed by 6/2 also exercises dbz clearing.
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, lat, bc);
            chk($sformatf("tbl%0d_lat", i),  lat, tbl[i].lat);
            chk($sformatf("tbl%0d_busy", i), bc, tbl[i].lat - 1);
            chk($sformatf("tbl%0d_q", i),    int'(bus.quotient), int'(tbl[i].q));
            chk($sformatf("tbl%0d_r", i),    int'(bus.remainder), int'(tbl[i].r));
            chk($sformatf("tbl%0d_dbz", i),  int'(bus.div_by_zero), int'(tbl[i].z));
        end
        repeat (2) @(posedge clk);

        // Done lasts exactly one cycle.
        run_op(4'd9, 4'd2, lat, bc);
        @(posedge clk); #1;
        chk("done_pulse_width", int'(bus.done), 0);

        // Start during RUN is ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
        @(negedge clk);
        bus.start = 1'b0; bus.dividend = 4'd0; bus.divisor = 4'd0;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd9; bus.divisor = 4'd4;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                dones++;
                chk("ign_q", int'(bus.quotient), 2);
                chk("ign_r", int'(bus.remainder), 2);
            end
        end
        chk("ign_done_cnt", dones, 1);

        // Back-to-back: new start held during DONE of 10/3.
        run_op(4'd10, 4'd3, lat, bc);
        chk("b2b_q0", int'(bus.quotient), 3);
        chk("b2b_r0", int'(bus.remainder), 1);
        bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b_busy", int'(bus.busy), 1);
        chk("b2b_hold_q", int'(bus.quotient), 3);
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_lat", lat, 5);
        chk("b2b_q1", int'(bus.quotient), 3);
        chk("b2b_r1", int'(bus.remainder), 2);
        repeat (2) @(posedge clk);

        // Reset mid-RUN discards the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_done", int'(bus.done), 0);
        chk("mrst_q",    int'(bus.quotient), 0);
        chk("mrst_r",    int'(bus.remainder), 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        chk("mrst_no_done", dones, 0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                check_op("exh", 4'(a), 4'(b));

        for (int i = 0; i < 40; i++)
            check_op("rnd", 4'($urandom_range(15)), 4'($urandom_range(15)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
